// File: rtl/l1c_pkg.sv
// Shared types and geometry helpers for the set-associative L1 instruction cache.
package l1c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL,
    DONE,
    FLUSH
  } state_t;

  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  // Byte-offset bits within a line: word select plus the two byte bits.
  function automatic int off_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets, input int line_words);
    return addr_w - off_w(line_words) - idx_w(sets);
  endfunction

endpackage

// File: rtl/l1c_victim_sel.sv
// Replacement choice: lowest invalid way, otherwise the set's round-robin pointer.
module l1c_victim_sel
  import l1c_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic [WAYS-1:0]  valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] victim,
  output logic             victim_invalid
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    victim         = ptr;
    victim_invalid = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) begin
        victim         = PTR_W'(w);
        victim_invalid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l1c_inst_assoc.sv
// Set-associative, read-only L1 instruction cache with whole-line refill and fence.i flush.
// Optional performance counters are enabled by defining L1C_PERF_CNT_EN.
module l1c_inst_assoc
  import l1c_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic [ADDR_W-1:0] core_addr,
  output logic [DATA_W-1:0] core_out,
  output logic              core_wait,
  input  logic              flush,
  output logic              I_req,
  output logic [ADDR_W-1:0] I_addr,
  input  logic [DATA_W-1:0] I_out,
  input  logic              I_wait
`ifdef L1C_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam int OFF    = off_w(LINE_WORDS);
  localparam int IDX    = idx_w(SETS);
  localparam int TAG    = tag_w(ADDR_W, SETS, LINE_WORDS);
  localparam int BEAT_W = OFF - 2;
  localparam int PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_t state, state_nxt;

  logic [ADDR_W-1:2] req_addr;
  logic [TAG-1:0]    req_tag;
  logic [IDX-1:0]    req_idx;
  logic [BEAT_W-1:0] req_word;

  logic [TAG-1:0]    tag_arr  [SETS][WAYS];
  word_t             data_arr [SETS][WAYS][LINE_WORDS];
  logic [WAYS-1:0]   valid_arr[SETS];
  logic [PTR_W-1:0]  rr_ptr   [SETS];
  word_t             line_buf [LINE_WORDS];

  logic [BEAT_W-1:0] beat;
  logic [PTR_W-1:0]  victim, victim_q;
  logic              victim_invalid, victim_inv_q;
  logic              flush_pend;
  logic              hit;
  logic [PTR_W-1:0]  hit_way;
  logic              beat_done, last_beat, go_flush;

  // Byte-select bits never affect a fetch; the name marks them as intentionally unused.
  logic addr_unused;
  assign addr_unused = ^core_addr[1:0];

  assign req_tag  = req_addr[ADDR_W-1 -: TAG];
  assign req_idx  = req_addr[OFF +: IDX];
  assign req_word = req_addr[2 +: BEAT_W];

  assign beat_done = (state == REFILL) && !I_wait;
  assign last_beat = beat_done && (beat == BEAT_W'(LINE_WORDS - 1));
  assign go_flush  = flush || flush_pend;

  // Parallel tag compare; scanning downward lets the lowest hitting way win.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_arr[req_idx][w] && (tag_arr[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = PTR_W'(w);
      end
    end
  end

  l1c_victim_sel #(
    .WAYS (WAYS),
    .PTR_W(PTR_W)
  ) u_victim_sel (
    .valid         (valid_arr[req_idx]),
    .ptr           (rr_ptr[req_idx]),
    .victim        (victim),
    .victim_invalid(victim_invalid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    core_wait = 1'b1;
    I_req     = 1'b0;
    I_addr    = '0;
    unique case (state)
      IDLE: begin
        core_wait = core_req;
        if (go_flush)      state_nxt = FLUSH;
        else if (core_req) state_nxt = LOOKUP;
      end
      LOOKUP: state_nxt = hit ? DONE : REFILL;
      REFILL: begin
        I_req  = 1'b1;
        I_addr = {req_tag, req_idx, beat, 2'b00};
        if (last_beat) state_nxt = DONE;
      end
      DONE: begin
        core_wait = 1'b0;
        state_nxt = IDLE;
      end
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // The stall is released during reset even if the core keeps requesting.
    if (rst) core_wait = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_addr     <= '0;
      core_out     <= '0;
      beat         <= '0;
      victim_q     <= '0;
      victim_inv_q <= 1'b0;
      flush_pend   <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_arr[s] <= '0;
        rr_ptr[s]    <= '0;
      end
    end else begin
      if (state == IDLE && core_req && !go_flush) req_addr <= core_addr[ADDR_W-1:2];

      if (state == LOOKUP) begin
        if (hit) begin
          core_out <= data_arr[req_idx][hit_way][req_word];
        end else begin
          victim_q     <= victim;
          victim_inv_q <= victim_invalid;
          beat         <= '0;
        end
      end

      if (beat_done) beat <= beat + 1'b1;

      if (last_beat) begin
        valid_arr[req_idx][victim_q] <= 1'b1;
        if (WAYS > 1 && !victim_inv_q) rr_ptr[req_idx] <= rr_ptr[req_idx] + 1'b1;
        core_out <= (req_word == BEAT_W'(LINE_WORDS - 1)) ? I_out : line_buf[req_word];
      end

      if (state == FLUSH) begin
        flush_pend <= 1'b0;
        for (int s = 0; s < SETS; s++) valid_arr[s] <= '0;
      end else if (flush && state != IDLE) begin
        flush_pend <= 1'b1;
      end
    end
  end

  // NOTE: tag and data storage carries no reset; the valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (beat_done) line_buf[beat] <= I_out;
    if (last_beat) begin
      tag_arr[req_idx][victim_q] <= req_tag;
      for (int i = 0; i < LINE_WORDS; i++) begin
        data_arr[req_idx][victim_q][i] <= (i == LINE_WORDS - 1) ? I_out : line_buf[i];
      end
    end
  end

`ifdef L1C_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      if (state == LOOKUP && hit)  hit_cnt   <= hit_cnt + 32'd1;
      if (state == LOOKUP && !hit) miss_cnt  <= miss_cnt + 32'd1;
      if (state == FLUSH)          flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l1c_inst_assoc.sv
// Scoreboard bench for l1c_inst_assoc: reference cache model, randomized fetches, stalls and flushes.
module tb_l1c_inst_assoc;

  localparam int SETS       = 64;
  localparam int WAYS       = 2;
  localparam int LINE_WORDS = 4;
  localparam int LINE_BYTES = LINE_WORDS * 4;

  logic        clk;
  logic        rst;
  logic        core_req;
  logic [31:0] core_addr;
  logic [31:0] core_out;
  logic        core_wait;
  logic        flush;
  logic        I_req;
  logic [31:0] I_addr;
  logic [31:0] I_out;
  logic        I_wait;
`ifdef L1C_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt, flush_cnt;
`endif

  l1c_inst_assoc #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .SETS      (SETS),
    .WAYS      (WAYS),
    .LINE_WORDS(LINE_WORDS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .core_req (core_req),
    .core_addr(core_addr),
    .core_out (core_out),
    .core_wait(core_wait),
    .flush    (flush),
    .I_req    (I_req),
    .I_addr   (I_addr),
    .I_out    (I_out),
    .I_wait   (I_wait)
`ifdef L1C_PERF_CNT_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: every word reads back as its own address plus 0xA000.
  assign I_out = I_addr + 32'hA000;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: no response within cycle budget", name);
  endtask

  // ---------------- reference model ----------------
  bit          m_valid[SETS][WAYS];
  int unsigned m_tag  [SETS][WAYS];
  int          m_ptr  [SETS];

  function automatic void model_flush();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
  endfunction

  function automatic void model_reset();
    model_flush();
    for (int s = 0; s < SETS; s++) m_ptr[s] = 0;
  endfunction

  // Returns 1 on hit; on miss installs the line in the chosen victim way.
  function automatic bit model_access(input logic [31:0] addr);
    int unsigned set = (addr / LINE_BYTES) % SETS;
    int unsigned tag = addr / (LINE_BYTES * SETS);
    int vict = -1;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[set][w] && m_tag[set][w] == tag) return 1'b1;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!m_valid[set][w]) vict = w;
    if (vict < 0) begin
      vict       = m_ptr[set];
      m_ptr[set] = (m_ptr[set] + 1) % WAYS;
    end
    m_valid[set][vict] = 1'b1;
    m_tag[set][vict]   = tag;
    return 1'b0;
  endfunction

  // ---------------- scoreboard and monitor ----------------
  typedef struct {
    logic [31:0] data;
    bit          miss;
    int          lat;
    logic [31:0] base;
  } exp_t;

  exp_t sb[$];
  bit   busy = 1'b0;
  int   cyc, beats_done, stall_cnt, stall_beat, stall_len;

  always @(negedge clk) begin
    if (busy) begin
      if (I_req) begin
        if (sb.size() > 0 && sb[0].miss)
          check("beat_addr", I_addr, sb[0].base + 32'(4 * beats_done));
        if (I_wait) stall_cnt++;
        else        beats_done++;
      end
      if (core_req && !core_wait) begin
        if (sb.size() == 0) begin
          timeout_fail("unexpected_response");
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("core_out", core_out, e.data);
          check("latency", 32'(cyc), 32'(e.lat));
          check("beat_count", 32'(beats_done), e.miss ? 32'(LINE_WORDS) : 32'd0);
        end
        busy = 1'b0;
      end
      cyc++;
    end
  end

  // Stall plan: hold I_wait for stall_len cycles on beat stall_beat.
  always @(posedge clk) begin
    #1;
    I_wait = I_req && (beats_done == stall_beat) && (stall_cnt < stall_len);
  end

  // flush_at: -1 none, 0 together with the request, >0 that many cycles later.
  task automatic fetch(input logic [31:0] addr, input int flush_at, input int s_beat, input int s_len);
    exp_t e;
    bit   h;
    int   c;
    if (flush_at == 0) model_flush();
    h      = model_access(addr);
    if (flush_at > 0) model_flush();
    e.data = {addr[31:2], 2'b00} + 32'hA000;
    e.miss = !h;
    e.base = addr & ~32'(LINE_BYTES - 1);
    e.lat  = (h ? 2 : LINE_WORDS + 2 + s_len) + ((flush_at == 0) ? 2 : 0);
    stall_beat = s_beat;
    stall_len  = h ? 0 : s_len;
    stall_cnt  = 0;
    beats_done = 0;
    cyc        = 0;
    sb.push_back(e);
    core_addr = addr;
    core_req  = 1'b1;
    flush     = (flush_at == 0);
    busy      = 1'b1;
    c = 0;
    while (busy && c < 100) begin
      @(posedge clk);
      #1;
      c++;
      flush = (c == flush_at);
    end
    if (busy) begin
      timeout_fail($sformatf("fetch_0x%08h", addr));
      finish_run();
    end
    flush    = 1'b0;
    core_req = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    rst       = 1'b1;
    core_req  = 1'b0;
    core_addr = '0;
    flush     = 1'b0;
    I_wait    = 1'b0;
    stall_len = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_core_out", core_out, 32'h0);
    check("rst_core_wait", {31'b0, core_wait}, 32'h0);
    check("rst_I_req", {31'b0, I_req}, 32'h0);
    check("rst_I_addr", I_addr, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Cold miss, then a hit in the same line.
    fetch(32'h100, -1, 0, 0);
    fetch(32'h108, -1, 0, 0);

    // Three tags in set 0x10 force a round-robin eviction.
    fetch(32'h100, -1, 0, 0);
    fetch(32'h500, -1, 0, 0);
    fetch(32'h900, -1, 0, 0);
    fetch(32'h100, -1, 0, 0);
    fetch(32'h900, -1, 0, 0);
    fetch(32'h500, -1, 0, 0);

    // Flush together with a request, then a cold miss stalled 3 cycles on beat 2.
    fetch(32'h000, 0, 0, 0);
    fetch(32'h100, -1, 2, 3);

    // Flush during the refill of 0x200; the refetch must miss.
    fetch(32'h200, 3, 0, 0);
    fetch(32'h200, -1, 0, 0);

    // Randomized traffic over two sets and four tags.
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      int r, fa, sbt, sl;
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(16, 17)) << 4)
        | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      r  = $urandom_range(0, 19);
      fa = (r == 0) ? 0 : ((r <= 2) ? r : -1);
      sbt = $urandom_range(0, LINE_WORDS - 1);
      sl  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
      fetch(a, fa, sbt, sl);
    end

    // Reset in the middle of beat 1 of a refill.
    stall_len = 0;
    core_addr = 32'h300;
    core_req  = 1'b1;
    c = 0;
    while (!(I_req && I_addr == 32'h304) && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (c >= 50) timeout_fail("reach_beat1");
    #1 rst = 1'b1;
    #1;
    check("midrst_I_req", {31'b0, I_req}, 32'h0);
    check("midrst_core_wait", {31'b0, core_wait}, 32'h0);
    check("midrst_I_addr", I_addr, 32'h0);
    core_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    check("post_rst_core_out", core_out, 32'h0);
    @(posedge clk);
    #1;
    fetch(32'h300, -1, 0, 0);
    fetch(32'h100, -1, 0, 0);
    fetch(32'h304, -1, 0, 0);

    finish_run();
  end

endmodule
